// File: rtl/barrel_shifter.sv
// Registered logarithmic barrel shifter for the FPU mantissa align/normalize path.
// EWR cascaded stages: stage k shifts by 2^k when its shift-amount bit is set.
// Each stage shifts left or right and fills vacated bits with a selectable bit.
// There is no rotation.
module barrel_shifter #(
  parameter int unsigned SWR = 26,
  parameter int unsigned EWR = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic [EWR-1:0] Shift_Value_i,
  input  logic [SWR-1:0] Shift_Data_i,
  input  logic           Left_Right_i,
  input  logic           Bit_Shift_i,
  output logic [SWR-1:0] N_mant_o
);

  // stage_data[k] is the operand entering stage k; stage_data[EWR] is the result.
  logic [SWR-1:0] stage_data [EWR+1];

  assign stage_data[0] = Shift_Data_i;

  for (genvar k = 0; k < EWR; k++) begin : g_stage
    localparam int unsigned SH = 32'd1 << k;
    logic [SWR-1:0] shifted;

    if (SH >= SWR) begin : g_flush
      // A shift by at least the full width pushes every data bit out.
      assign shifted = {SWR{Bit_Shift_i}};
    end else begin : g_shift
      // Shift by 2^k in the selected direction, filling with Bit_Shift_i.
      always_comb begin
        if (Left_Right_i) begin
          shifted = {stage_data[k][SWR-1-SH:0], {SH{Bit_Shift_i}}};
        end else begin
          shifted = {{SH{Bit_Shift_i}}, stage_data[k][SWR-1:SH]};
        end
      end
    end

    assign stage_data[k+1] = Shift_Value_i[k] ? shifted : stage_data[k];
  end

  // Output register: async clear, capture the shifted result under load_i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      N_mant_o <= '0;
    end else if (load_i) begin
      N_mant_o <= stage_data[EWR];
    end
  end

endmodule

// File: tb/tb_barrel_shifter.sv
// Directed self-checking bench for barrel_shifter (SWR=26, EWR=5).
module tb_barrel_shifter;

  localparam int unsigned SWR = 26;
  localparam int unsigned EWR = 5;

  logic           clk;
  logic           rst;
  logic           load_i;
  logic [EWR-1:0] Shift_Value_i;
  logic [SWR-1:0] Shift_Data_i;
  logic           Left_Right_i;
  logic           Bit_Shift_i;
  logic [SWR-1:0] N_mant_o;

  int checks = 0;
  int errors = 0;

  barrel_shifter #(.SWR(SWR), .EWR(EWR)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_i        (load_i),
    .Shift_Value_i (Shift_Value_i),
    .Shift_Data_i  (Shift_Data_i),
    .Left_Right_i  (Left_Right_i),
    .Bit_Shift_i   (Bit_Shift_i),
    .N_mant_o      (N_mant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation at the falling edge, then sample 1 ns after the rising edge.
  task automatic issue(input logic [EWR-1:0] n, input logic lr, input logic fill,
                       input logic [SWR-1:0] d, input logic ld);
    @(negedge clk);
    Shift_Value_i = n;
    Left_Right_i  = lr;
    Bit_Shift_i   = fill;
    Shift_Data_i  = d;
    load_i        = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    issue(5'd4, 1'b0, 1'b0, 26'h2345678, 1'b1);
    checks++;
    if (N_mant_o !== 26'h0234567) begin
      errors++;
      $display("FAIL reset_preload: got %h expected %h", N_mant_o, 26'h0234567);
    end
    // Assert rst mid-cycle with load pending: output must clear without an edge.
    @(negedge clk);
    Shift_Value_i = 5'd3;
    Shift_Data_i  = 26'h3FFFFFF;
    Left_Right_i  = 1'b1;
    Bit_Shift_i   = 1'b1;
    load_i        = 1'b1;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (N_mant_o !== 26'h0) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", N_mant_o, 26'h0);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (N_mant_o !== 26'h0) begin
        errors++;
        $display("FAIL reset_hold edge %0d: got %h expected %h", i, N_mant_o, 26'h0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_right();
    issue(5'd4, 1'b0, 1'b0, 26'h2345678, 1'b1);
    checks++;
    if (N_mant_o !== 26'h0234567) begin
      errors++;
      $display("FAIL right4_fill0: got %h expected %h", N_mant_o, 26'h0234567);
    end
    issue(5'd4, 1'b0, 1'b1, 26'h2345678, 1'b1);
    checks++;
    if (N_mant_o !== 26'h3E34567) begin
      errors++;
      $display("FAIL right4_fill1: got %h expected %h", N_mant_o, 26'h3E34567);
    end
    issue(5'd25, 1'b0, 1'b0, 26'h2000000, 1'b1);
    checks++;
    if (N_mant_o !== 26'h0000001) begin
      errors++;
      $display("FAIL right25: got %h expected %h", N_mant_o, 26'h0000001);
    end
  endtask

  task automatic test_left();
    issue(5'd4, 1'b1, 1'b0, 26'h2345678, 1'b1);
    checks++;
    if (N_mant_o !== 26'h3456780) begin
      errors++;
      $display("FAIL left4_fill0: got %h expected %h", N_mant_o, 26'h3456780);
    end
    issue(5'd25, 1'b1, 1'b0, 26'h0000001, 1'b1);
    checks++;
    if (N_mant_o !== 26'h2000000) begin
      errors++;
      $display("FAIL left25: got %h expected %h", N_mant_o, 26'h2000000);
    end
    issue(5'd8, 1'b1, 1'b1, 26'h0000001, 1'b1);
    checks++;
    if (N_mant_o !== 26'h00001FF) begin
      errors++;
      $display("FAIL left8_fill1: got %h expected %h", N_mant_o, 26'h00001FF);
    end
  endtask

  task automatic test_zero_shift();
    issue(5'd0, 1'b0, 1'b1, 26'h2345678, 1'b1);
    checks++;
    if (N_mant_o !== 26'h2345678) begin
      errors++;
      $display("FAIL zero_right: got %h expected %h", N_mant_o, 26'h2345678);
    end
    issue(5'd0, 1'b1, 1'b1, 26'h2345678, 1'b1);
    checks++;
    if (N_mant_o !== 26'h2345678) begin
      errors++;
      $display("FAIL zero_left: got %h expected %h", N_mant_o, 26'h2345678);
    end
  endtask

  task automatic test_max_shift();
    issue(5'd31, 1'b0, 1'b1, 26'h2345678, 1'b1);
    checks++;
    if (N_mant_o !== 26'h3FFFFFF) begin
      errors++;
      $display("FAIL right31_fill1: got %h expected %h", N_mant_o, 26'h3FFFFFF);
    end
    issue(5'd31, 1'b1, 1'b1, 26'h2345678, 1'b1);
    checks++;
    if (N_mant_o !== 26'h3FFFFFF) begin
      errors++;
      $display("FAIL left31_fill1: got %h expected %h", N_mant_o, 26'h3FFFFFF);
    end
    issue(5'd26, 1'b1, 1'b0, 26'h3FFFFFF, 1'b1);
    checks++;
    if (N_mant_o !== 26'h0) begin
      errors++;
      $display("FAIL left26_fill0: got %h expected %h", N_mant_o, 26'h0);
    end
  endtask

  // Right sweep against D>>n, then every direction/fill against a bitwise model.
  task automatic test_sweep();
    logic [SWR-1:0] d;
    logic [SWR-1:0] exp;
    d = 26'h2345678;
    for (int n = 1; n < 32; n++) begin
      issue(EWR'(n), 1'b0, 1'b0, d, 1'b1);
      exp = (n >= 26) ? 26'h0 : (d >> n);
      checks++;
      if (N_mant_o !== exp) begin
        errors++;
        $display("FAIL sweep_right n=%0d: got %h expected %h", n, N_mant_o, exp);
      end
    end
    d = 26'h1A5C3E7;
    for (int mode = 0; mode < 4; mode++) begin
      for (int n = 0; n < 32; n++) begin
        issue(EWR'(n), mode[1], mode[0], d, 1'b1);
        for (int i = 0; i < 26; i++) begin
          if (mode[1]) exp[i] = (i >= n) ? d[i-n] : mode[0];
          else         exp[i] = (i + n < 26) ? d[i+n] : mode[0];
        end
        checks++;
        if (N_mant_o !== exp) begin
          errors++;
          $display("FAIL sweep_model lr=%0d fill=%0d n=%0d: got %h expected %h",
                   mode[1], mode[0], n, N_mant_o, exp);
        end
      end
    end
  endtask

  task automatic test_hold();
    issue(5'd4, 1'b1, 1'b0, 26'h2345678, 1'b1);
    checks++;
    if (N_mant_o !== 26'h3456780) begin
      errors++;
      $display("FAIL hold_load: got %h expected %h", N_mant_o, 26'h3456780);
    end
    for (int i = 0; i < 3; i++) begin
      issue(EWR'(i + 1), i[0], ~i[0], 26'h1555555 ^ SWR'(i), 1'b0);
      checks++;
      if (N_mant_o !== 26'h3456780) begin
        errors++;
        $display("FAIL hold_cycle %0d: got %h expected %h", i, N_mant_o, 26'h3456780);
      end
    end
    // Inputs toggled between edges with load high must not disturb the output.
    Shift_Value_i = 5'd1;
    load_i = 1'b1;
    #2;
    checks++;
    if (N_mant_o !== 26'h3456780) begin
      errors++;
      $display("FAIL hold_between_edges: got %h expected %h", N_mant_o, 26'h3456780);
    end
  endtask

  task automatic test_back_to_back();
    issue(5'd1, 1'b0, 1'b0, 26'h0000010, 1'b1);
    checks++;
    if (N_mant_o !== 26'h0000008) begin
      errors++;
      $display("FAIL b2b_0: got %h expected %h", N_mant_o, 26'h0000008);
    end
    issue(5'd2, 1'b1, 1'b0, 26'h0000010, 1'b1);
    checks++;
    if (N_mant_o !== 26'h0000040) begin
      errors++;
      $display("FAIL b2b_1: got %h expected %h", N_mant_o, 26'h0000040);
    end
    issue(5'd16, 1'b0, 1'b1, 26'h3000000, 1'b1);
    checks++;
    if (N_mant_o !== 26'h3FFFF00) begin
      errors++;
      $display("FAIL b2b_2: got %h expected %h", N_mant_o, 26'h3FFFF00);
    end
  endtask

  task automatic test_reset_midstream();
    issue(5'd4, 1'b0, 1'b0, 26'h2345678, 1'b1);
    @(negedge clk);
    Shift_Value_i = 5'd2;
    Left_Right_i  = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (N_mant_o !== 26'h0) begin
      errors++;
      $display("FAIL midstream_async: got %h expected %h", N_mant_o, 26'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (N_mant_o !== 26'h0) begin
      errors++;
      $display("FAIL midstream_discard: got %h expected %h", N_mant_o, 26'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    issue(5'd2, 1'b1, 1'b0, 26'h2345678, 1'b1);
    checks++;
    if (N_mant_o !== 26'h0D159E0) begin
      errors++;
      $display("FAIL after_release: got %h expected %h", N_mant_o, 26'h0D159E0);
    end
  endtask

  initial begin
    rst           = 1'b0;
    load_i        = 1'b0;
    Shift_Value_i = '0;
    Shift_Data_i  = '0;
    Left_Right_i  = 1'b0;
    Bit_Shift_i   = 1'b0;
    test_reset();
    test_right();
    test_left();
    test_zero_shift();
    test_max_shift();
    test_sweep();
    test_hold();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
